bcd_converter_param: RTL and testbench

//  Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
//  one input bit per clock. Generalised in input width and output digit count.

---
 rtl/bcd_converter_param.sv | 145 ++++++++++++++
 tb/tb_bcd_converter_param.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter_param.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Adds saturating overflow and a significant-digit count for leading-zero blanking.
module bcd_converter_param #(
   parameter int unsigned BIN_WIDTH  = 32,
   parameter int unsigned BCD_DIGITS = 10,
   localparam int unsigned DCNT_W    = $clog2(BCD_DIGITS + 1)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic [BIN_WIDTH-1:0]    binary_i,
   output logic                    ready_o,
   output logic                    done_o,
   output logic [4*BCD_DIGITS-1:0] BCD_o,
   output logic                    overflow_o,
   output logic [DCNT_W-1:0]       digits_o
);

   // Enough digits to hold any BIN_WIDTH value: ceil(BIN_WIDTH*log10(2)) + 1.
   localparam int unsigned ACC_DIGITS = (BIN_WIDTH * 30103 + 99999) / 100000 + 1;
   localparam int unsigned ACC_W      = 4 * ACC_DIGITS;
   localparam int unsigned OUT_W      = 4 * BCD_DIGITS;
   localparam int unsigned CNT_W      = $clog2(BIN_WIDTH + 1);

   // 10**BCD_DIGITS, clamped to 2**BIN_WIDTH when it exceeds the input range so the
   // overflow compare can never fire in that case.
   function automatic logic [BIN_WIDTH:0] pow10_limit();
      logic [BIN_WIDTH:0]   p;
      logic [BIN_WIDTH+4:0] t;
      p = (BIN_WIDTH+1)'(1);
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
         t = {4'b0000, p} * (BIN_WIDTH+5)'(10);
         if (t[BIN_WIDTH+4:BIN_WIDTH] != 5'd0) p = {1'b1, {BIN_WIDTH{1'b0}}};
         else                                  p = t[BIN_WIDTH:0];
      end
      return p;
   endfunction

   localparam logic [BIN_WIDTH:0] OVF_LIMIT = pow10_limit();

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e                 state_q, state_d;
   logic [BIN_WIDTH-1:0]   shift_q, shift_d;
   logic [ACC_W-1:0]       acc_q, acc_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic [OUT_W-1:0]       bcd_q, bcd_d;
   logic                   overflow_q, overflow_d;
   logic [DCNT_W-1:0]      digits_q, digits_d;
   logic                   done_q, done_d;

   logic [ACC_W-1:0]           adj;
   logic [ACC_W+BIN_WIDTH-1:0] dabble;
   logic [OUT_W-1:0]           res;
   logic [DCNT_W-1:0]          sig_digits;

   // Add-3 correction on every digit >= 5, then shift the next binary bit in.
   always_comb begin
      adj = acc_q;
      for (int i = 0; i < int'(ACC_DIGITS); i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      dabble = {adj, shift_q} << 1;
   end

   // Low BCD_DIGITS of the accumulator and the index of its highest nonzero digit.
   always_comb begin
      res        = OUT_W'(acc_q);
      sig_digits = DCNT_W'(1);
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
         if (res[4*i +: 4] != 4'd0) sig_digits = DCNT_W'(i + 1);
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      bcd_d      = bcd_q;
      overflow_d = overflow_q;
      digits_d   = digits_q;
      done_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               shift_d = binary_i;
               acc_d   = '0;
               cnt_d   = CNT_W'(BIN_WIDTH);
               ovf_d   = ({1'b0, binary_i} >= OVF_LIMIT);
               state_d = StShift;
            end
         end
         StShift: begin
            acc_d   = dabble[ACC_W+BIN_WIDTH-1:BIN_WIDTH];
            shift_d = dabble[BIN_WIDTH-1:0];
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = StDone;
         end
         StDone: begin
            bcd_d      = ovf_q ? {BCD_DIGITS{4'h9}} : res;
            overflow_d = ovf_q;
            digits_d   = ovf_q ? DCNT_W'(BCD_DIGITS) : sig_digits;
            done_d     = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and result registers; reset aborts any conversion in flight.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         shift_q    <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         bcd_q      <= '0;
         overflow_q <= 1'b0;
         digits_q   <= DCNT_W'(1);
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         bcd_q      <= bcd_d;
         overflow_q <= overflow_d;
         digits_q   <= digits_d;
         done_q     <= done_d;
      end
   end

   assign ready_o    = (state_q == StIdle);
   assign done_o     = done_q;
   assign BCD_o      = bcd_q;
   assign overflow_o = overflow_q;
   assign digits_o   = digits_q;

endmodule

// File: tb/tb_bcd_converter_param.sv
// Bench for bcd_converter_param: default 32-bit/10-digit instance plus a
// 16-bit/4-digit instance for saturation; expected results flow through queues.
module tb_bcd_converter_param;

   localparam int unsigned WA = 32, DA = 10, WB = 16, DB = 4;
   localparam int unsigned DCA = $clog2(DA + 1), DCB = $clog2(DB + 1);

   typedef struct {
      logic [63:0] bin;
      logic [63:0] bcd;
      logic [63:0] digits;
      logic        ovf;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0;
   logic [WA-1:0] bin_a = '0;
   logic [WB-1:0] bin_b = '0;
   logic rdy_a, done_a, ovf_a, rdy_b, done_b, ovf_b;
   logic [4*DA-1:0] bcd_a;
   logic [4*DB-1:0] bcd_b;
   logic [DCA-1:0]  dig_a;
   logic [DCB-1:0]  dig_b;

   vec_t qa[$], qb[$];
   int n_checks = 0, n_pass = 0;
   int done_cnt_a = 0, done_cnt_b = 0;
   logic prev_done_a = 1'b0, prev_done_b = 1'b0;

   always #5 clk = ~clk;

   bcd_converter_param #(.BIN_WIDTH(WA), .BCD_DIGITS(DA)) dut_a (
      .clk_i(clk), .reset_i(rst), .start_i(start_a), .binary_i(bin_a), .ready_o(rdy_a),
      .done_o(done_a), .BCD_o(bcd_a), .overflow_o(ovf_a), .digits_o(dig_a));

   bcd_converter_param #(.BIN_WIDTH(WB), .BCD_DIGITS(DB)) dut_b (
      .clk_i(clk), .reset_i(rst), .start_i(start_b), .binary_i(bin_b), .ready_o(rdy_b),
      .done_o(done_b), .BCD_o(bcd_b), .overflow_o(ovf_b), .digits_o(dig_b));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Reference model: repeated division, independent of the shift-and-add algorithm.
   function automatic vec_t model(input logic [63:0] v, input int nd);
      vec_t r;
      logic [63:0] x;
      r.bin = v; r.bcd = '0; r.digits = 64'd1; r.ovf = 1'b0; x = v;
      for (int i = 0; i < nd; i++) begin
         r.bcd[4*i +: 4] = 4'(x % 10);
         if (x % 10 != 0) r.digits = 64'(i + 1);
         x = x / 10;
      end
      return r;
   endfunction

   // Scoreboard: pop and compare whenever an instance reports done.
   always @(negedge clk) begin : mon_a
      vec_t e;
      if (done_a) begin
         done_cnt_a++;
         check("a_done_pulse_width", 64'(prev_done_a), 64'd0);
         if (qa.size() == 0) check("a_unexpected_done", 64'(qa.size()), 64'd1);
         else begin
            e = qa.pop_front();
            check("a_bcd", 64'(bcd_a), e.bcd);
            check("a_digits", 64'(dig_a), e.digits);
            check("a_overflow", 64'(ovf_a), 64'(e.ovf));
         end
      end
      prev_done_a = done_a;
   end

   always @(negedge clk) begin : mon_b
      vec_t e;
      if (done_b) begin
         done_cnt_b++;
         check("b_done_pulse_width", 64'(prev_done_b), 64'd0);
         if (qb.size() == 0) check("b_unexpected_done", 64'(qb.size()), 64'd1);
         else begin
            e = qb.pop_front();
            check("b_bcd", 64'(bcd_b), e.bcd);
            check("b_digits", 64'(dig_b), e.digits);
            check("b_overflow", 64'(ovf_b), 64'(e.ovf));
         end
      end
      prev_done_b = done_b;
   end

   task automatic wait_ready(input bit sel);
      int n = 0;
      while (!(sel ? rdy_b : rdy_a) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) check("ready_timeout", 64'(sel ? rdy_b : rdy_a), 64'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) check("done_timeout", 64'(qa.size() + qb.size()), 64'd0);
   endtask

   task automatic convert(input bit sel, input vec_t v);
      wait_ready(sel);
      if (sel) begin bin_b = v.bin[WB-1:0]; start_b = 1'b1; qb.push_back(v); end
      else     begin bin_a = v.bin[WA-1:0]; start_a = 1'b1; qa.push_back(v); end
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      wait_drain();
   endtask

   vec_t tab_a[8];
   vec_t tab_b[7];

   initial begin
      int n, base;
      vec_t v;
      tab_a[0] = '{64'd5,          64'h5,          64'd1,  1'b0};
      tab_a[1] = '{64'hFFFFFFFF,   64'h4294967295, 64'd10, 1'b0};
      tab_a[2] = '{64'd0,          64'h0,          64'd1,  1'b0};
      tab_a[3] = '{64'd1000,       64'h1000,       64'd4,  1'b0};
      tab_a[4] = '{64'd9,          64'h9,          64'd1,  1'b0};
      tab_a[5] = '{64'd10,         64'h10,         64'd2,  1'b0};
      tab_a[6] = '{64'd99999999,   64'h99999999,   64'd8,  1'b0};
      tab_a[7] = '{64'd1234567890, 64'h1234567890, 64'd10, 1'b0};
      tab_b[0] = '{64'd12345, 64'h9999, 64'd4, 1'b1};
      tab_b[1] = '{64'd9999,  64'h9999, 64'd4, 1'b0};
      tab_b[2] = '{64'd10000, 64'h9999, 64'd4, 1'b1};
      tab_b[3] = '{64'd65535, 64'h9999, 64'd4, 1'b1};
      tab_b[4] = '{64'd0,     64'h0,    64'd1, 1'b0};
      tab_b[5] = '{64'd7,     64'h7,    64'd1, 1'b0};
      tab_b[6] = '{64'd100,   64'h100,  64'd3, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(rdy_a), 64'd1);
      check("rst_done", 64'(done_a), 64'd0);
      check("rst_bcd", 64'(bcd_a), 64'd0);
      check("rst_overflow", 64'(ovf_a), 64'd0);
      check("rst_digits", 64'(dig_a), 64'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Latency: accept edge counts as edge 1; done_o visible after edge BIN_WIDTH+2.
      wait_ready(1'b0);
      bin_a = 32'd5; start_a = 1'b1; qa.push_back(tab_a[0]);
      @(posedge clk); #1;
      start_a = 1'b0;
      check("busy_after_accept", 64'(rdy_a), 64'd0);
      n = 0;
      while (!done_a && n < 100) begin @(posedge clk); #1; n++; end
      check("latency_edges", 64'(n + 1), 64'(WA + 2));
      check("ready_with_done", 64'(rdy_a), 64'd1);
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done_a), 64'd0);
      wait_drain();

      for (int i = 0; i < 8; i++) convert(1'b0, tab_a[i]);
      for (int i = 0; i < 7; i++) convert(1'b1, tab_b[i]);
      for (int i = 0; i < 6; i++) convert(1'b0, model(64'($urandom()), DA));

      // Held start with changing input: only the first value is converted.
      base = done_cnt_a;
      wait_ready(1'b0);
      start_a = 1'b1; bin_a = 32'd777; qa.push_back(model(64'd777, DA));
      @(posedge clk); #1; bin_a = 32'd123;
      check("held_start_busy1", 64'(rdy_a), 64'd0);
      @(posedge clk); #1; bin_a = 32'd456;
      check("held_start_busy2", 64'(rdy_a), 64'd0);
      @(posedge clk); #1; start_a = 1'b0;
      wait_drain();
      repeat (40) @(posedge clk);
      #1;
      check("held_start_one_done", 64'(done_cnt_a - base), 64'd1);

      // Reset in the middle of SHIFT aborts with no done pulse.
      base = done_cnt_a;
      wait_ready(1'b0);
      start_a = 1'b1; bin_a = 32'hDEADBEEF;
      @(posedge clk); #1; start_a = 1'b0;
      repeat (10) @(posedge clk);
      #1; rst = 1'b1; #1;
      check("abort_ready", 64'(rdy_a), 64'd1);
      check("abort_bcd", 64'(bcd_a), 64'd0);
      check("abort_digits", 64'(dig_a), 64'd1);
      check("abort_overflow", 64'(ovf_a), 64'd0);
      @(posedge clk); #1; rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_cnt_a - base), 64'd0);
      v = model(64'd1000, DA);
      convert(1'b0, v);
      check("scoreboard_empty", 64'(qa.size() + qb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
